// File: rtl/switch_pkg.sv
// Shared definitions for the switch port blocks: frame constants,
// address width and the transmit-port state encoding.
package switch_pkg;

  localparam int         ADDR_W   = 8;
  localparam logic [7:0] PREAMBLE = 8'hFE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SHIFT   = 2'd2,
    RELEASE = 2'd3
  } port_tx_state_t;

  // Frame length in bits: preamble, source, destination, then payload.
  function automatic int frame_bits(input int payload_bytes);
    return 8 * (3 + payload_bytes);
  endfunction

endpackage

// File: rtl/frame_piso.sv
// Parallel-in serial-out frame shifter. Loads a whole frame, then moves
// it out MSB first one bit per shift_en. sout always shows the next bit.
module frame_piso #(
  parameter int WIDTH = 56
) (
  input  logic             core_clock,
  input  logic             core_rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  // Load has priority; shifting fills with zeros from the LSB end.
  always_ff @(posedge core_clock) begin
    if (core_rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift_en) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = sreg[WIDTH-1];

endmodule

// File: rtl/port_tx.sv
// Switch port transmitter. Captures a frame on send, requests the
// arbiter, serialises the frame with a two-cycle-per-bit strobe once
// granted, and releases the grant. Every output is a flop.
module port_tx
  import switch_pkg::*;
#(
  parameter int                PAYLOAD_BYTES = 4,
  parameter logic [ADDR_W-1:0] SRC_ADDR      = 8'h01,
  parameter int                GNT_TIMEOUT   = 64
) (
  input  logic                       core_clock,
  input  logic                       core_rst,
  input  logic                       send,
  input  logic [ADDR_W-1:0]          dest_addr,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  input  logic                       gnt,
  output logic                       req,
  output logic                       dout,
  output logic                       clk_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int N_BITS = frame_bits(PAYLOAD_BYTES);
  localparam int BIT_W  = $clog2(N_BITS + 1);
  localparam int WAIT_W = $clog2(GNT_TIMEOUT + 1);

  port_tx_state_t    state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              phase, phase_nxt;
  logic              req_nxt, dout_nxt, clk_out_nxt, busy_nxt, done_nxt, err_nxt;
  logic              load, shift_en, piso_sout;
  logic [N_BITS-1:0] frame_word;

  assign frame_word = {PREAMBLE, SRC_ADDR, dest_addr, payload};

  // The shifter doubles as the capture register: loaded only from IDLE,
  // so a send strobe in any other state cannot disturb the frame.
  frame_piso #(
    .WIDTH(N_BITS)
  ) u_piso (
    .core_clock(core_clock),
    .core_rst  (core_rst),
    .load      (load),
    .shift_en  (shift_en),
    .din       (frame_word),
    .sout      (piso_sout)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    wait_cnt_nxt = wait_cnt;
    phase_nxt    = phase;
    req_nxt      = req;
    dout_nxt     = 1'b0;
    clk_out_nxt  = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;

    case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (send) begin
          load      = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end

      REQ: begin
        req_nxt = 1'b1;
        if (gnt) begin
          // First bit goes out in the cycle right after the grant.
          dout_nxt  = piso_sout;
          shift_en  = 1'b1;
          state_nxt = SHIFT;
        end else if (wait_cnt == WAIT_W'(GNT_TIMEOUT - 1)) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      SHIFT: begin
        if (!gnt) begin
          // Grant lost mid-frame: abandon the frame.
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (!phase) begin
          // Second half of the bit: hold data, raise strobe at mid-bit.
          dout_nxt    = dout;
          clk_out_nxt = 1'b1;
          phase_nxt   = 1'b1;
        end else if (bit_cnt == BIT_W'(N_BITS - 1)) begin
          req_nxt   = 1'b0;
          state_nxt = RELEASE;
        end else begin
          dout_nxt    = piso_sout;
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          phase_nxt   = 1'b0;
        end
      end

      RELEASE: begin
        req_nxt = 1'b0;
        if (!gnt) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    // Counters start from zero in every state.
    if (state_nxt != state) begin
      bit_cnt_nxt  = '0;
      wait_cnt_nxt = '0;
      phase_nxt    = 1'b0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State, counters and all outputs registered; reset clears everything.
  always_ff @(posedge core_clock) begin
    if (core_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      phase    <= 1'b0;
      req      <= 1'b0;
      dout     <= 1'b0;
      clk_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      phase    <= phase_nxt;
      req      <= req_nxt;
      dout     <= dout_nxt;
      clk_out  <= clk_out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: doc/port_tx.md
PORT_TX -- requirements
Module: port_tx

Interface
REQ-001 Parameter: PAYLOAD_BYTES, default 4, number of payload bytes per frame (1..16).
REQ-002 Parameter: SRC_ADDR, default 8'h01, source address byte inserted in every frame.
REQ-003 Parameter: GNT_TIMEOUT, default 64, maximum core_clock cycles spent waiting for gnt.
REQ-004 Port: core_clock  input  1  single clock; all logic on rising edge.
REQ-005 Port: core_rst  input  1  reset, synchronous and active-high.
REQ-006 Port: send  input  1  host strobe; frame capture when sampled high in IDLE.
REQ-007 Port: dest_addr  input  8  destination address byte; captured with send.
REQ-008 Port: payload  input  8*PAYLOAD_BYTES  payload; byte [8*PAYLOAD_BYTES-1 -: 8] sent first; captured with send.
REQ-009 Port: gnt  input  1  grant from switch arbiter.
REQ-010 Port: req  output  1  request to switch arbiter.
REQ-011 Port: dout  output  1  serial frame data, MSB of each byte first.
REQ-012 Port: clk_out  output  1  bit strobe to arbiter; rising edge at mid-bit.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle pulse on successful frame completion.
REQ-015 Port: err  output  1  one-cycle pulse on timeout or grant loss.

Function
REQ-016 Frame SHALL be: preamble 8'hFE, SRC_ADDR, dest_addr, payload bytes; total bits N = 8*(3+PAYLOAD_BYTES).
REQ-017 FSM states SHALL be IDLE, REQ, SHIFT, RELEASE.
REQ-018 IDLE: send=1 -> capture dest_addr/payload, req=1 next cycle, go REQ; send=0 -> stay.
REQ-019 REQ: req=1; gnt=1 -> go SHIFT; wait counter reaching GNT_TIMEOUT with gnt=0 -> req=0, err pulse, go IDLE.
REQ-020 SHIFT: each bit SHALL occupy exactly 2 cycles: cycle A dout=bit, clk_out=0; cycle B dout=bit, clk_out=1.
REQ-021 First bit SHALL appear on dout the cycle after gnt is sampled high; last bit's cycle B ends SHIFT (2N cycles total).
REQ-022 After bit N: clk_out=0, dout=0, req=0, go RELEASE.
REQ-023 RELEASE: wait for gnt=0; on gnt=0 -> done pulse for one cycle, go IDLE.
REQ-024 gnt=0 sampled in SHIFT SHALL abort: req=0, dout=0, clk_out=0, err pulse, go IDLE next cycle; no done.
REQ-025 send SHALL be ignored in REQ, SHIFT, RELEASE; captured data SHALL NOT change until IDLE.
REQ-026 dout and clk_out SHALL be 0 in IDLE, REQ, RELEASE.
REQ-027 Bit counter width SHALL be clog2(N+1); wait counter width clog2(GNT_TIMEOUT+1); both clear on every state entry.
REQ-028 done and err SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered (no combinational path from gnt/send to any output).

Reset
REQ-030 core_rst=1 SHALL force state IDLE and req, dout, clk_out, busy, done, err, counters, shift register to 0 at the next edge.
REQ-031 Reset mid-frame SHALL drop req the following cycle with no done/err pulse.

Structure
REQ-032 Shared package switch_pkg SHALL hold PREAMBLE (8'hFE), ADDR_W (8), and the port_tx state enum.
REQ-033 Parallel-in serial-out shifter SHALL be one sub-module, frame_piso (load, shift-enable, MSB-first serial out).

Verification
REQ-034 dest_addr=8'h03, payload=32'hA5C30F01, gnt after 5 cycles -> dout bits FE 01 03 A5 C3 0F 01, 56 clk_out rising edges, 112 SHIFT cycles, req=0 after, done pulse after gnt drops.
REQ-035 gnt never asserted, GNT_TIMEOUT=64 -> req high 64 cycles, then req=0, single err pulse, busy=0.
REQ-036 gnt dropped at bit 20 -> abort next cycle, dout=0, clk_out=0, err pulse, no done, no further clk_out edges.
REQ-037 send pulsed again during SHIFT with payload=32'hFFFFFFFF -> transmitted frame unchanged (still A5C30F01).
REQ-038 core_rst asserted at bit 10 -> all outputs 0 next cycle; new send after reset -> full correct frame.
REQ-039 PAYLOAD_BYTES=1, payload=8'h5A -> 32 bits FE 01 dd 5A, done pulse, back to IDLE.
